// File: rtl/regfile_sync.sv
// Parametrised CPU register file: clocked write port, two read ports with optional
// bypass, hardwired-zero entry 0, selectable read latency and a post-reset clear sequencer.
module regfile_sync #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 32,
    parameter int AW           = 5,
    parameter int ZERO_REG     = 1,
    parameter int BYPASS       = 1,
    parameter int READ_LATENCY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    readreg1,
    input  logic [AW-1:0]    readreg2,
    input  logic [AW-1:0]    writereg,
    input  logic [WIDTH-1:0] writedata,
    input  logic             regwrite,
    output logic [WIDTH-1:0] readdata1,
    output logic [WIDTH-1:0] readdata2,
    output logic             busy
);

    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [AW:0]       clr_idx_q, clr_idx_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              wr_eff;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              rd1_ok, rd2_ok;
    logic [WIDTH-1:0]  rd1_d, rd2_d;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy_d    = busy_q;
        if (state_q == CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == LAST_IDX) begin
                state_d = READY;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_eff = regwrite && !busy_q && ({1'b0, writereg} < DEPTH_W)
                    && !((ZERO_REG != 0) && (writereg == '0));

    // The clear sequencer and the architectural write share the single memory write port.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = writereg;
        mem_wdata = writedata;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx_q[AW-1:0];
            mem_wdata = '0;
        end else if (wr_eff) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd1_ok = ({1'b0, readreg1} < DEPTH_W) && !((ZERO_REG != 0) && (readreg1 == '0));
    assign rd2_ok = ({1'b0, readreg2} < DEPTH_W) && !((ZERO_REG != 0) && (readreg2 == '0));

    always_comb begin
        rd1_d = '0;
        if (!busy_q && rd1_ok) begin
            if ((BYPASS != 0) && wr_eff && (writereg == readreg1)) begin
                rd1_d = writedata;
            end else begin
                rd1_d = mem[readreg1];
            end
        end
    end

    always_comb begin
        rd2_d = '0;
        if (!busy_q && rd2_ok) begin
            if ((BYPASS != 0) && wr_eff && (writereg == readreg2)) begin
                rd2_d = writedata;
            end else begin
                rd2_d = mem[readreg2];
            end
        end
    end

    // rd*_d is already zero while busy, so the registered path needs only the reset clear.
    generate
        if (READ_LATENCY == 0) begin : g_comb_read
            assign readdata1 = rd1_d;
            assign readdata2 = rd2_d;
        end else begin : g_reg_read
            logic [WIDTH-1:0] rdata1_q, rdata2_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata1_q <= '0;
                    rdata2_q <= '0;
                end else begin
                    rdata1_q <= rd1_d;
                    rdata2_q <= rd2_d;
                end
            end
            assign readdata1 = rdata1_q;
            assign readdata2 = rdata2_q;
        end
    endgenerate

    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_sync.sv
// Directed bench for regfile_sync: four parameterisations share one stimulus stream
// and each scenario task checks the instances it concerns.
module tb_regfile_sync;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  readreg1 = '0;
    logic [4:0]  readreg2 = '0;
    logic [4:0]  writereg = '0;
    logic [31:0] writedata = '0;
    logic        regwrite = 1'b0;

    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_c, rd2_c, rd1_d, rd2_d;
    logic        busy_a, busy_b, busy_c, busy_d;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // a: defaults (zero reg, bypass, comb read)
    regfile_sync #(.ZERO_REG(1), .BYPASS(1), .READ_LATENCY(0)) u_a (
        .clk(clk), .reset(reset), .readreg1(readreg1), .readreg2(readreg2),
        .writereg(writereg), .writedata(writedata), .regwrite(regwrite),
        .readdata1(rd1_a), .readdata2(rd2_a), .busy(busy_a));

    // b: no zero reg, no bypass, comb read
    regfile_sync #(.ZERO_REG(0), .BYPASS(0), .READ_LATENCY(0)) u_b (
        .clk(clk), .reset(reset), .readreg1(readreg1), .readreg2(readreg2),
        .writereg(writereg), .writedata(writedata), .regwrite(regwrite),
        .readdata1(rd1_b), .readdata2(rd2_b), .busy(busy_b));

    // c: registered read
    regfile_sync #(.ZERO_REG(1), .BYPASS(1), .READ_LATENCY(1)) u_c (
        .clk(clk), .reset(reset), .readreg1(readreg1), .readreg2(readreg2),
        .writereg(writereg), .writedata(writedata), .regwrite(regwrite),
        .readdata1(rd1_c), .readdata2(rd2_c), .busy(busy_c));

    // d: 20-entry file with 5-bit addresses
    regfile_sync #(.DEPTH(20), .AW(5)) u_d (
        .clk(clk), .reset(reset), .readreg1(readreg1), .readreg2(readreg2),
        .writereg(writereg), .writedata(writedata), .regwrite(regwrite),
        .readdata1(rd1_d), .readdata2(rd2_d), .busy(busy_d));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts busy samples per instance after reset release, checking zero outputs while busy.
    task automatic run_clear(input int drive_write_cycles,
                             output int cnt_a, output int cnt_b,
                             output int cnt_c, output int cnt_d);
        int zero_errs;
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; zero_errs = 0;
        for (int i = 0; i < 40; i++) begin
            regwrite = (i < drive_write_cycles);
            readreg1 = 5'(i);
            readreg2 = 5'(31 - i);
            #1;
            if (busy_a === 1'b1) cnt_a++;
            if (busy_b === 1'b1) cnt_b++;
            if (busy_c === 1'b1) cnt_c++;
            if (busy_d === 1'b1) cnt_d++;
            if (busy_a === 1'b1 && (rd1_a !== 32'd0 || rd2_a !== 32'd0)) zero_errs++;
            if (busy_b === 1'b1 && (rd1_b !== 32'd0 || rd2_b !== 32'd0)) zero_errs++;
            if (busy_c === 1'b1 && (rd1_c !== 32'd0 || rd2_c !== 32'd0)) zero_errs++;
            step();
        end
        regwrite = 1'b0;
        tests++;
        if (zero_errs !== 0) begin
            fails++;
            $display("FAIL clear_outputs_zero: %0d nonzero samples while busy, required 0", zero_errs);
        end
    endtask

    task automatic check_counts(input string tag, input int ca, input int cb,
                                input int cc, input int cd);
        tests += 4;
        if (ca !== 32) begin fails++; $display("FAIL %s busy_a: got %0d cycles, required 32", tag, ca); end
        if (cb !== 32) begin fails++; $display("FAIL %s busy_b: got %0d cycles, required 32", tag, cb); end
        if (cc !== 32) begin fails++; $display("FAIL %s busy_c: got %0d cycles, required 32", tag, cc); end
        if (cd !== 20) begin fails++; $display("FAIL %s busy_d: got %0d cycles, required 20", tag, cd); end
    endtask

    task automatic test_reset();
        int ca, cb, cc, cd, errs;
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++;
        if (busy_a !== 1'b1 || rd1_c !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: busy=%b rd1_c=%h, required busy=1 rd1_c=0", busy_a, rd1_c);
        end
        run_clear(0, ca, cb, cc, cd);
        check_counts("initial_clear", ca, cb, cc, cd);
        errs = 0;
        for (int i = 0; i < 32; i++) begin
            readreg1 = 5'(i);
            readreg2 = 5'(31 - i);
            #1;
            if (rd1_a !== 32'd0 || rd2_a !== 32'd0 || rd1_b !== 32'd0 || rd2_b !== 32'd0) errs++;
        end
        tests++;
        if (errs !== 0) begin
            fails++;
            $display("FAIL cleared_contents: %0d nonzero reads, required 0", errs);
        end
    endtask

    task automatic test_bypass();
        step();
        readreg1  = 5'd7;
        writereg  = 5'd7;
        writedata = 32'hDEADBEEF;
        regwrite  = 1'b1;
        #1;
        tests += 2;
        if (rd1_a !== 32'hDEADBEEF) begin
            fails++; $display("FAIL bypass_same_cycle: got %h, required deadbeef", rd1_a);
        end
        if (rd1_b !== 32'd0) begin
            fails++; $display("FAIL nobypass_same_cycle: got %h, required 00000000", rd1_b);
        end
        step();
        regwrite = 1'b0;
        #1;
        tests += 2;
        if (rd1_b !== 32'hDEADBEEF) begin
            fails++; $display("FAIL nobypass_next_cycle: got %h, required deadbeef", rd1_b);
        end
        if (rd1_a !== 32'hDEADBEEF) begin
            fails++; $display("FAIL bypass_next_cycle: got %h, required deadbeef", rd1_a);
        end
    endtask

    task automatic test_zero_reg();
        writereg  = 5'd0;
        writedata = 32'h12345678;
        regwrite  = 1'b1;
        readreg1  = 5'd0;
        step();
        regwrite = 1'b0;
        #1;
        tests += 2;
        if (rd1_a !== 32'd0) begin
            fails++; $display("FAIL zero_reg_on: got %h, required 00000000", rd1_a);
        end
        if (rd1_b !== 32'h12345678) begin
            fails++; $display("FAIL zero_reg_off: got %h, required 12345678", rd1_b);
        end
    endtask

    task automatic test_latency();
        readreg1 = 5'd0;
        readreg2 = 5'd0;
        step();
        readreg1 = 5'd7;
        readreg2 = 5'd7;
        #1;
        tests += 2;
        if (rd2_c !== 32'd0) begin
            fails++; $display("FAIL latency_cycle_n: got %h, required 00000000", rd2_c);
        end
        if (rd1_a !== rd2_a || rd2_a !== 32'hDEADBEEF) begin
            fails++; $display("FAIL same_addr_comb: got %h/%h, required deadbeef/deadbeef", rd1_a, rd2_a);
        end
        step();
        tests += 2;
        if (rd2_c !== 32'hDEADBEEF) begin
            fails++; $display("FAIL latency_cycle_n1: got %h, required deadbeef", rd2_c);
        end
        if (rd1_c !== 32'hDEADBEEF) begin
            fails++; $display("FAIL same_addr_reg: got %h, required deadbeef", rd1_c);
        end
    endtask

    task automatic test_reset_restart();
        int ca, cb, cc, cd;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        tests++;
        if (busy_a !== 1'b1) begin
            fails++; $display("FAIL restart_mid_clear: busy=%b, required 1", busy_a);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        writereg  = 5'd3;
        writedata = 32'h0000CAFE;
        run_clear(15, ca, cb, cc, cd);
        check_counts("restart_clear", ca, cb, cc, cd);
        readreg1 = 5'd3;
        readreg2 = 5'd7;
        #1;
        tests += 2;
        if (rd1_a !== 32'd0 || rd1_b !== 32'd0) begin
            fails++; $display("FAIL busy_write_dropped: got %h/%h, required 0/0", rd1_a, rd1_b);
        end
        if (rd2_a !== 32'd0) begin
            fails++; $display("FAIL restart_cleared: got %h, required 00000000", rd2_a);
        end
    endtask

    task automatic test_depth();
        step();
        writereg  = 5'd25;
        writedata = 32'h000000AA;
        regwrite  = 1'b1;
        readreg1  = 5'd25;
        #1;
        tests++;
        if (rd1_d !== 32'd0) begin
            fails++; $display("FAIL oob_bypass: got %h, required 00000000", rd1_d);
        end
        step();
        regwrite = 1'b0;
        #1;
        tests += 2;
        if (rd1_d !== 32'd0) begin
            fails++; $display("FAIL oob_write_dropped: got %h, required 00000000", rd1_d);
        end
        if (rd1_a !== 32'h000000AA) begin
            fails++; $display("FAIL inrange_reg25: got %h, required 000000aa", rd1_a);
        end
        writereg  = 5'd19;
        writedata = 32'h00000055;
        regwrite  = 1'b1;
        step();
        regwrite = 1'b0;
        readreg2 = 5'd19;
        #1;
        tests++;
        if (rd2_d !== 32'h00000055) begin
            fails++; $display("FAIL last_entry_rw: got %h, required 00000055", rd2_d);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_latency();
        test_reset_restart();
        test_depth();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
